// File: rtl/pipelined_rca_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rca_addsub_if
// Description : Operand/result valid-ready bundle for pipelined_rca_addsub.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_rca_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_rca_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_rca_addsub
// Description : WIDTH-bit add/sub split into STAGES ripple slices, with the
//               inter-slice carry registered and a global valid/ready stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_rca_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input wire clk,
    input wire rst_n,
    pipelined_rca_addsub_if.slave bus
);
    localparam int c_slice = WIDTH / STAGES;

    logic w_adv;
    logic r_ovf;

    assign w_adv        = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_lo = k * c_slice;
        // Operand bits still to be consumed from this stage onward
        localparam int c_aw = WIDTH - c_lo;

        logic [c_aw-1:0]         w_ain;
        logic [c_aw-1:0]         w_bin;
        logic                    w_cin;
        logic                    w_vin;
        logic [c_slice-1:0]      w_s;
        logic [c_slice:0]        w_c;
        logic                    r_valid;
        logic                    r_carry;
        logic [c_lo+c_slice-1:0] r_sum;

        always_comb begin
            w_s    = '0;
            w_c    = '0;
            w_c[0] = w_cin;
            for (int i = 0; i < c_slice; i++) begin
                w_s[i]   = w_ain[i] ^ w_bin[i] ^ w_c[i];
                w_c[i+1] = (w_ain[i] & w_bin[i]) | (w_c[i] & (w_ain[i] ^ w_bin[i]));
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_vin;
                r_carry <= w_c[c_slice];
            end
        end

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; the +1 rides in on the slice-0 carry
            assign w_ain = bus.a;
            assign w_bin = bus.sub ? ~bus.b : bus.b;
            assign w_cin = bus.sub | bus.c_in;
            assign w_vin = bus.in_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_sum <= w_s;
                end
            end
        end else begin : g_next
            assign w_ain = g_stage[k-1].g_skew.r_a;
            assign w_bin = g_stage[k-1].g_skew.r_b;
            assign w_cin = g_stage[k-1].r_carry;
            assign w_vin = g_stage[k-1].r_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_sum <= {w_s, g_stage[k-1].r_sum};
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [c_aw-c_slice-1:0] r_a;
            logic [c_aw-c_slice-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_ain[c_aw-1:c_slice];
                    r_b <= w_bin[c_aw-1:c_slice];
                end
            end
        end else begin : g_last
            // Signed overflow: carry into the MSB differs from carry out of it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_c[c_slice] ^ w_c[c_slice-1];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_valid;
    assign bus.sum       = g_stage[STAGES-1].r_sum;
    assign bus.cout      = g_stage[STAGES-1].r_carry;
    assign bus.overflow  = r_ovf;
endmodule
`default_nettype wire
